// File: rtl/pipelined_ctrl_unit.sv
// Registered RV32I+Zicsr decode/control stage with valid/ready handshake,
// stall/flush handling, illegal-instruction flagging and CSR/MRET serialisation.
module pipelined_ctrl_unit #(
  parameter int EN_CSR      = 1,
  parameter int CSR_BUBBLES = 2,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [3:0]  alu_op,
  output logic        reg_wr,
  output logic        sel_A,
  output logic        sel_B,
  output logic        rd_en,
  output logic        wr_en,
  output logic [1:0]  wb_sel,
  output logic [2:0]  br_type,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic [2:0]  mem_size,
  output logic        csr_rd,
  output logic        csr_wr,
  output logic [1:0]  csr_op,
  output logic        is_mret,
  output logic        illegal,
  output logic        serial_busy
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SRA   = 4'd2;
  localparam logic [3:0] ALU_SRL   = 4'd3;
  localparam logic [3:0] ALU_SLL   = 4'd4;
  localparam logic [3:0] ALU_AND   = 4'd5;
  localparam logic [3:0] ALU_OR    = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_UPPER = 4'd10;

  localparam bit SERIALISE = (EN_CSR != 0) && (CSR_BUBBLES > 0);

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_wr;
    logic       sel_a;
    logic       sel_b;
    logic       rd_en;
    logic       wr_en;
    logic [1:0] wb_sel;
    logic [2:0] br_type;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic [2:0] mem_size;
    logic       csr_rd;
    logic       csr_wr;
    logic [1:0] csr_op;
    logic       is_mret;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {IDLE = 1'b0, SERIAL = 1'b1} state_t;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [4:0] rs1;
  logic       unused_rd;

  assign opcode    = instr[6:0];
  assign func3     = instr[14:12];
  assign func7     = instr[31:25];
  assign rs1       = instr[19:15];
  assign unused_rd = ^instr[11:7];

  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  ctrl_t dec;
  logic  dec_bad;

  always_comb begin
    dec     = '0;
    dec_bad = 1'b0;
    case (opcode)
      7'h33: begin
        dec.reg_wr = 1'b1;
        dec.sel_a  = 1'b1;
        dec.wb_sel = 2'b01;
        if (func7 == 7'h00)                         dec.alu_op = alu_of_f3(func3);
        else if (func7 == 7'h20 && func3 == 3'b000) dec.alu_op = ALU_SUB;
        else if (func7 == 7'h20 && func3 == 3'b101) dec.alu_op = ALU_SRA;
        else                                        dec_bad = 1'b1;
      end
      7'h13: begin
        dec.reg_wr = 1'b1;
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.wb_sel = 2'b01;
        // Only the shift-immediates constrain the upper bits; elsewhere they are immediate.
        case (func3)
          3'b001: begin
            if (func7 == 7'h00) dec.alu_op = ALU_SLL;
            else                dec_bad = 1'b1;
          end
          3'b101: begin
            if (func7 == 7'h00)      dec.alu_op = ALU_SRL;
            else if (func7 == 7'h20) dec.alu_op = ALU_SRA;
            else                     dec_bad = 1'b1;
          end
          default: dec.alu_op = alu_of_f3(func3);
        endcase
      end
      7'h03: begin
        dec.rd_en    = 1'b1;
        dec.reg_wr   = 1'b1;
        dec.sel_a    = 1'b1;
        dec.sel_b    = 1'b1;
        dec.wb_sel   = 2'b10;
        dec.mem_size = func3;
        dec_bad      = !(func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      7'h23: begin
        dec.wr_en    = 1'b1;
        dec.sel_a    = 1'b1;
        dec.sel_b    = 1'b1;
        dec.mem_size = func3;
        dec_bad      = !(func3 inside {3'b000, 3'b001, 3'b010});
      end
      7'h63: begin
        dec.is_branch = 1'b1;
        dec.sel_b     = 1'b1;
        dec.br_type   = func3;
        dec_bad       = (func3 == 3'b010) || (func3 == 3'b011);
      end
      7'h37: begin
        dec.reg_wr = 1'b1;
        dec.sel_b  = 1'b1;
        dec.wb_sel = 2'b01;
        dec.alu_op = ALU_UPPER;
      end
      7'h17: begin
        dec.reg_wr = 1'b1;
        dec.sel_b  = 1'b1;
        dec.wb_sel = 2'b01;
      end
      7'h6F: begin
        dec.is_jal = 1'b1;
        dec.reg_wr = 1'b1;
        dec.sel_b  = 1'b1;
      end
      7'h67: begin
        dec.is_jalr = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.sel_a   = 1'b1;
        dec.sel_b   = 1'b1;
        dec_bad     = (func3 != 3'b000);
      end
      7'h73: begin
        if (EN_CSR != 0 && func3 inside {3'b001, 3'b010, 3'b011}) begin
          dec.csr_rd = 1'b1;
          dec.reg_wr = 1'b1;
          dec.wb_sel = 2'b11;
          dec.csr_op = func3[1:0];
          dec.csr_wr = (func3 == 3'b001) || (rs1 != 5'd0);
        end else if (EN_CSR != 0 && func3 == 3'b000 && instr[31:20] == 12'h302) begin
          dec.is_mret = 1'b1;
        end else begin
          dec_bad = 1'b1;
        end
      end
      default: dec_bad = 1'b1;
    endcase
    if (dec_bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  ctrl_t  ctrl_q, ctrl_d;
  logic   out_valid_q, out_valid_d;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic   accept;

  assign in_ready = rst & ~stall & (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      ctrl_d      = '0;
      out_valid_d = 1'b0;
    end else if (stall) begin
      ctrl_d      = ctrl_q;
      out_valid_d = out_valid_q;
    end else if (accept) begin
      ctrl_d      = dec;
      out_valid_d = 1'b1;
    end else begin
      ctrl_d      = '0;
      out_valid_d = 1'b0;
    end
  end

  // Bubble counter only advances on non-stalled cycles so stalls do not eat bubbles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (SERIALISE && accept && (dec.csr_rd || dec.is_mret)) begin
            state_d = SERIAL;
            cnt_d   = CNT_W'(CSR_BUBBLES);
          end
        end
        default: begin
          if (!stall) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_op      = ctrl_q.alu_op;
  assign reg_wr      = ctrl_q.reg_wr;
  assign sel_A       = ctrl_q.sel_a;
  assign sel_B       = ctrl_q.sel_b;
  assign rd_en       = ctrl_q.rd_en;
  assign wr_en       = ctrl_q.wr_en;
  assign wb_sel      = ctrl_q.wb_sel;
  assign br_type     = ctrl_q.br_type;
  assign is_branch   = ctrl_q.is_branch;
  assign is_jal      = ctrl_q.is_jal;
  assign is_jalr     = ctrl_q.is_jalr;
  assign mem_size    = ctrl_q.mem_size;
  assign csr_rd      = ctrl_q.csr_rd;
  assign csr_wr      = ctrl_q.csr_wr;
  assign csr_op      = ctrl_q.csr_op;
  assign is_mret     = ctrl_q.is_mret;
  assign illegal     = ctrl_q.illegal;
  assign serial_busy = (state_q == SERIAL);

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Directed bench for pipelined_ctrl_unit: a decode vector table plus hand-written
// reset, throughput, stall, CSR serialisation and flush sequences.
module tb_pipelined_ctrl_unit;

  typedef struct packed {
    logic       ov;
    logic [3:0] alu;
    logic       rw, sa, sb, rd, wr;
    logic [1:0] wb;
    logic [2:0] br;
    logic       isb, jal, jalr;
    logic [2:0] msz;
    logic       crd, cwr;
    logic [1:0] cop;
    logic       mret, ill;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [31:0] instr;

  logic        in_ready, out_valid, reg_wr, sel_A, sel_B, rd_en, wr_en;
  logic        is_branch, is_jal, is_jalr, csr_rd, csr_wr, is_mret, illegal, serial_busy;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel, csr_op;
  logic [2:0]  br_type, mem_size;

  logic        n_in_ready, n_out_valid, n_reg_wr, n_sel_A, n_sel_B, n_rd_en, n_wr_en;
  logic        n_is_branch, n_is_jal, n_is_jalr, n_csr_rd, n_csr_wr, n_is_mret, n_illegal, n_serial_busy;
  logic [3:0]  n_alu_op;
  logic [1:0]  n_wb_sel, n_csr_op;
  logic [2:0]  n_br_type, n_mem_size;

  exp_t obs, n_obs;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipelined_ctrl_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .stall(stall), .flush(flush), .out_valid(out_valid), .alu_op(alu_op),
    .reg_wr(reg_wr), .sel_A(sel_A), .sel_B(sel_B), .rd_en(rd_en), .wr_en(wr_en),
    .wb_sel(wb_sel), .br_type(br_type), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .mem_size(mem_size), .csr_rd(csr_rd), .csr_wr(csr_wr),
    .csr_op(csr_op), .is_mret(is_mret), .illegal(illegal), .serial_busy(serial_busy)
  );

  pipelined_ctrl_unit #(.EN_CSR(0)) dut_nocsr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .instr(instr),
    .stall(stall), .flush(flush), .out_valid(n_out_valid), .alu_op(n_alu_op),
    .reg_wr(n_reg_wr), .sel_A(n_sel_A), .sel_B(n_sel_B), .rd_en(n_rd_en), .wr_en(n_wr_en),
    .wb_sel(n_wb_sel), .br_type(n_br_type), .is_branch(n_is_branch), .is_jal(n_is_jal),
    .is_jalr(n_is_jalr), .mem_size(n_mem_size), .csr_rd(n_csr_rd), .csr_wr(n_csr_wr),
    .csr_op(n_csr_op), .is_mret(n_is_mret), .illegal(n_illegal), .serial_busy(n_serial_busy)
  );

  assign obs = {out_valid, alu_op, reg_wr, sel_A, sel_B, rd_en, wr_en, wb_sel, br_type,
                is_branch, is_jal, is_jalr, mem_size, csr_rd, csr_wr, csr_op, is_mret, illegal};
  assign n_obs = {n_out_valid, n_alu_op, n_reg_wr, n_sel_A, n_sel_B, n_rd_en, n_wr_en,
                  n_wb_sel, n_br_type, n_is_branch, n_is_jal, n_is_jalr, n_mem_size,
                  n_csr_rd, n_csr_wr, n_csr_op, n_is_mret, n_illegal};

  function automatic exp_t ex(int alu, int rw, int sa, int sb, int rd, int wr, int wb,
                              int br, int isb, int jal, int jalr, int msz, int crd,
                              int cwr, int cop, int mret, int ill);
    exp_t e;
    e.ov = 1'b1;     e.alu = 4'(alu);   e.rw = 1'(rw);     e.sa = 1'(sa);
    e.sb = 1'(sb);   e.rd = 1'(rd);     e.wr = 1'(wr);     e.wb = 2'(wb);
    e.br = 3'(br);   e.isb = 1'(isb);   e.jal = 1'(jal);   e.jalr = 1'(jalr);
    e.msz = 3'(msz); e.crd = 1'(crd);   e.cwr = 1'(cwr);   e.cop = 2'(cop);
    e.mret = 1'(mret); e.ill = 1'(ill);
    return e;
  endfunction

  function automatic exp_t rtype(int alu);
    return ex(alu, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t itype(int alu);
    return ex(alu, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t ill_e();
    return ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic void add(string nm, logic [31:0] ins, exp_t e);
    vec_t v;
    v.nm = nm; v.ins = ins; v.e = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e_add, e_lw;
    e_add = rtype(0);
    e_lw  = ex(0, 1, 1, 1, 1, 0, 2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);

    add("add",    32'h003100B3, rtype(0));
    add("sub",    32'h403100B3, rtype(1));
    add("sra",    32'h403150B3, rtype(2));
    add("srl",    32'h003150B3, rtype(3));
    add("sll",    32'h003110B3, rtype(4));
    add("and",    32'h003170B3, rtype(5));
    add("or",     32'h003160B3, rtype(6));
    add("xor",    32'h003140B3, rtype(7));
    add("slt",    32'h003120B3, rtype(8));
    add("sltu",   32'h003130B3, rtype(9));
    add("r_f7_20_f3_1", 32'h403110B3, ill_e());
    add("r_f7_01", 32'h023100B3, ill_e());
    add("addi",   32'h00510093, itype(0));
    add("srai",   32'h40315093, itype(2));
    add("slli",   32'h00311093, itype(4));
    add("slli_f7_20", 32'h40311093, ill_e());
    add("andi",   32'h00517093, itype(5));
    add("xori_m1", 32'hFFF14093, itype(7));
    add("lw",     32'h0000A083, e_lw);
    add("lbu",    32'h0000C083, ex(0, 1, 1, 1, 1, 0, 2, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
    add("ld_ill", 32'h0000B083, ill_e());
    add("sw",     32'h00312023, ex(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    add("sd_ill", 32'h00313023, ill_e());
    add("beq",    32'h00208063, ex(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("bge",    32'h0020D063, ex(0, 0, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("br_f3_2", 32'h0020A063, ill_e());
    add("lui",    32'h123450B7, ex(10, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("auipc",  32'h00001097, ex(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("jal",    32'h000000EF, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add("jalr",   32'h000100E7, ex(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add("jalr_f3_1", 32'h000110E7, ill_e());
    add("csrrw",  32'h300110F3, ex(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    add("csrrs_x0", 32'h300020F3, ex(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    add("csrrs_x2", 32'h300120F3, ex(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0));
    add("csrrc_x0", 32'h300030F3, ex(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
    add("mret",   32'h30200073, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add("ecall",  32'h00000073, ill_e());
    add("csrrwi", 32'h300050F3, ill_e());
    add("op_7f",  32'h0000007F, ill_e());

    // Reset held with a valid instruction offered
    rst = 1'b0; in_valid = 1'b1; instr = 32'h003100B3; stall = 1'b0; flush = 1'b0;
    repeat (3) step();
    chk("rst_outputs", 32'(obs), 32'd0);
    chk("rst_busy", 32'(serial_busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    // Throughput: add then sub on consecutive cycles
    step();
    in_valid = 1'b1; instr = 32'h003100B3;
    step();
    chk("tp_add", 32'(obs), 32'(e_add));
    instr = 32'h403100B3;
    chk("tp_ready_still", 32'(in_ready), 32'd1);
    step();
    chk("tp_sub", 32'(obs), 32'(rtype(1)));
    in_valid = 1'b0;
    step();
    chk("tp_bubble", 32'(obs), 32'd0);

    // Stall holds outputs while a new instruction waits
    in_valid = 1'b1; instr = 32'h0000A083;
    step();
    chk("st_lw", 32'(obs), 32'(e_lw));
    stall = 1'b1; instr = 32'h003100B3;
    #1;
    chk("st_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("st_hold1", 32'(obs), 32'(e_lw));
    step();
    chk("st_hold2", 32'(obs), 32'(e_lw));
    stall = 1'b0;
    #1;
    chk("st_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("st_next_add", 32'(obs), 32'(e_add));
    in_valid = 1'b0;
    step();

    // CSR serialisation: exactly two not-ready cycles
    in_valid = 1'b1; instr = 32'h300110F3;
    step();
    chk("csr_rw", 32'(obs), 32'(ex(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)));
    instr = 32'h300020F3;
    chk("csr_ready_c1", 32'(in_ready), 32'd0);
    chk("csr_busy", 32'(serial_busy), 32'd1);
    step();
    chk("csr_ready_c2", 32'(in_ready), 32'd0);
    chk("csr_bubble", 32'(out_valid), 32'd0);
    step();
    chk("csr_ready_c3", 32'(in_ready), 32'd1);
    step();
    chk("csr_rs_x0", 32'(obs), 32'(ex(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0)));
    in_valid = 1'b0;
    wait_ready();

    // Flush during serialisation, then flush together with stall
    in_valid = 1'b1; instr = 32'h300110F3;
    step();
    in_valid = 1'b0;
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_outputs", 32'(obs), 32'd0);
    chk("fl_busy", 32'(serial_busy), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; instr = 32'h003100B3;
    step();
    in_valid = 1'b0;
    chk("fl_add", 32'(obs), 32'(e_add));
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    chk("fl_beats_stall", 32'(obs), 32'd0);
    step();

    // Decode table, also checked against the CSR-disabled instance
    foreach (vecs[i]) begin
      exp_t en;
      wait_ready();
      in_valid = 1'b1; instr = vecs[i].ins;
      step();
      in_valid = 1'b0;
      chk(vecs[i].nm, 32'(obs), 32'(vecs[i].e));
      en = (vecs[i].ins[6:0] == 7'h73) ? ill_e() : vecs[i].e;
      chk({"nocsr_", vecs[i].nm}, 32'(n_obs), 32'(en));
      chk({"ready_after_", vecs[i].nm}, 32'(in_ready),
          32'(!(vecs[i].e.crd || vecs[i].e.mret)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
